// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the datapath (master) and the
// data-segment responder (slave).
interface data_mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        stall;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, err, stall
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, err, stall
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-segment RAM responder: accepts one word load/store per request,
// completes it LATENCY cycles later with a one-cycle ready pulse, and stalls the core meanwhile.
module data_mem_responder #(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h10010000
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    logic          cur_we;
    logic [31:0]   cur_addr, cur_wdata;
    logic [29:0]   word_off;
    logic [IW-1:0] idx;
    logic          fault;
    logic          access;
    logic          ready;

    // With LATENCY=1 the access happens on the acceptance edge, before the
    // latched copy exists, so the live bus fields are used while in IDLE.
    always_comb begin
        cur_we    = (state_q == IDLE) ? bus.we    : we_q;
        cur_addr  = (state_q == IDLE) ? bus.addr  : addr_q;
        cur_wdata = (state_q == IDLE) ? bus.wdata : wdata_q;
        word_off  = cur_addr[31:2] - BASE[31:2];
        idx       = word_off[IW-1:0];
        fault     = (cur_addr[1:0] != 2'b00) || (cur_addr < BASE) || (word_off >= 30'(DEPTH));
        access    = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.req) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && access && cur_we && !fault) begin
            mem[idx] <= cur_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= access && fault;
            if (access && (fault || !cur_we)) begin
                rdata_q <= fault ? '0 : mem[idx];
            end
        end
    end

    always_comb begin
        ready     = (state_q == DONE);
        bus.ready = ready;
        bus.err   = err_q;
        bus.rdata = rdata_q;
        bus.stall = bus.req & ~ready;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized checks of data_mem_responder at LATENCY=3 and LATENCY=1
// against a transaction-level memory model.
module tb_data_mem_responder;
    localparam logic [31:0] BASE  = 32'h10010000;
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstA, rstB;
    data_mem_responder_if ifA();
    data_mem_responder_if ifB();

    data_mem_responder #(.LATENCY(3), .DEPTH(DEPTH), .BASE(BASE)) dutA (
        .clk(clk), .reset(rstA), .bus(ifA)
    );
    data_mem_responder #(.LATENCY(1), .DEPTH(DEPTH), .BASE(BASE)) dutB (
        .clk(clk), .reset(rstB), .bus(ifB)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [longint unsigned];
    logic [31:0] rd_exp [2];
    bit          rd_known [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned lat(input int sel);
        return (sel == 0) ? 3 : 1;
    endfunction

    function automatic bit is_fault(input logic [31:0] a);
        longint unsigned ua = 64'(a);
        longint unsigned lo = 64'(BASE);
        longint unsigned hi = 64'(BASE) + 64'(4 * DEPTH);
        return (a % 4 != 0) || (ua < lo) || (ua >= hi);
    endfunction

    function automatic longint unsigned key_of(input int sel, input logic [31:0] a);
        return 64'(sel) * 64'h1_0000_0000 + 64'((a - BASE) / 4);
    endfunction

    task automatic drive(input int sel, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
        if (sel == 0) begin ifA.req = r; ifA.we = w; ifA.addr = a; ifA.wdata = d; end
        else          begin ifB.req = r; ifB.we = w; ifB.addr = a; ifB.wdata = d; end
    endtask

    task automatic sample(input int sel, output logic rdy, output logic e, output logic s,
                          output logic [31:0] rd);
        if (sel == 0) begin rdy = ifA.ready; e = ifA.err; s = ifA.stall; rd = ifA.rdata; end
        else          begin rdy = ifB.ready; e = ifB.err; s = ifB.stall; rd = ifB.rdata; end
    endtask

    task automatic idle_check(input int sel, input string tag);
        logic rdy, e, s;
        logic [31:0] rd;
        @(negedge clk);
        sample(sel, rdy, e, s, rd);
        chk({tag, ".idle_ready"}, 32'(rdy), 0);
        chk({tag, ".idle_err"}, 32'(e), 0);
        chk({tag, ".idle_stall"}, 32'(s), 0);
        if (rd_known[sel]) chk({tag, ".idle_rdata"}, rd, rd_exp[sel]);
        @(posedge clk); #1;
    endtask

    // Called at the start of a cycle in which the DUT is IDLE; returns at the start
    // of the first cycle after the ready cycle (plus one idle cycle unless keep=1).
    task automatic txn(input int sel, input string tag, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input bit keep, input bit drop);
        int unsigned L = lat(sel);
        bit f = is_fault(a);
        longint unsigned key = key_of(sel, a);
        logic [31:0] exp_rd = '0;
        bit chk_rd = 1'b0;
        logic rdy, e, s;
        logic [31:0] rd;
        if (f) begin exp_rd = '0; chk_rd = 1'b1; end
        else if (we) begin exp_rd = rd_exp[sel]; chk_rd = rd_known[sel]; end
        else if (mdl.exists(key)) begin exp_rd = mdl[key]; chk_rd = 1'b1; end
        drive(sel, 1'b1, we, a, d);
        for (int unsigned k = 0; k <= L; k++) begin
            @(negedge clk);
            sample(sel, rdy, e, s, rd);
            if (k < L) begin
                chk({tag, ".ready_lo"}, 32'(rdy), 0);
                chk({tag, ".err_lo"}, 32'(e), 0);
                chk({tag, ".stall"}, 32'(s), (drop && k >= 1) ? 0 : 1);
                if (rd_known[sel]) chk({tag, ".rdata_held"}, rd, rd_exp[sel]);
            end else begin
                chk({tag, ".ready"}, 32'(rdy), 1);
                chk({tag, ".err"}, 32'(e), 32'(f));
                chk({tag, ".stall_done"}, 32'(s), 0);
                if (chk_rd) chk({tag, ".rdata"}, rd, exp_rd);
            end
            @(posedge clk); #1;
            if (k == 0) drive(sel, !drop, 1'($urandom), $urandom, $urandom);
        end
        if (!f && we) mdl[key] = d;
        if (f || !we) begin rd_exp[sel] = exp_rd; rd_known[sel] = chk_rd; end
        if (!keep) begin
            drive(sel, 1'b0, 1'b0, '0, '0);
            idle_check(sel, tag);
        end
    endtask

    // Store accepted, then reset during the first BUSY cycle: no write, no ready.
    task automatic reset_mid(input logic [31:0] a, input logic [31:0] d);
        logic rdy, e, s;
        logic [31:0] rd;
        drive(0, 1'b1, 1'b1, a, d);
        @(negedge clk);
        sample(0, rdy, e, s, rd);
        chk("rst_mid.accept_stall", 32'(s), 1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        rstA = 1'b1;
        @(posedge clk); #1;
        rstA = 1'b0;
        rd_exp[0] = '0; rd_known[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sample(0, rdy, e, s, rd);
            chk("rst_mid.no_ready", 32'(rdy), 0);
            chk("rst_mid.rdata_cleared", rd, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic rand_txn(input int sel, input int n);
        logic [31:0] a;
        bit drop, keep;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: a = BASE + 32'(4 * $urandom_range(0, 7));
                7: a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
                8: a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
                default: a = ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : 32'hFFFF_FFFC;
            endcase
            drop = (sel == 0) && ($urandom_range(0, 3) == 0);
            keep = !drop && ($urandom_range(0, 1) == 1);
            txn(sel, (sel == 0) ? "randA" : "randB", 1'($urandom), a, $urandom, keep, drop);
        end
        if (keep) begin
            drive(sel, 1'b0, 1'b0, '0, '0);
            idle_check(sel, "rand_end");
        end
    endtask

    initial begin
        logic rdy, e, s;
        logic [31:0] rd;
        rd_known[0] = 1'b0; rd_known[1] = 1'b0;
        rd_exp[0] = '0; rd_exp[1] = '0;
        rstA = 1'b1; rstB = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rstA = 1'b0; rstB = 1'b0;
        for (int sel = 0; sel < 2; sel++) begin
            @(negedge clk);
            sample(sel, rdy, e, s, rd);
            chk("reset.ready", 32'(rdy), 0);
            chk("reset.err", 32'(e), 0);
            chk("reset.stall", 32'(s), 0);
            chk("reset.rdata", rd, 0);
            rd_known[sel] = 1'b1;
        end
        @(posedge clk); #1;

        txn(0, "pre0", 1'b1, 32'h10010004, 32'h0BAD_F00D, 0, 0);
        txn(0, "pre1", 1'b1, 32'h10010000, 32'h1111_1111, 0, 0);
        txn(0, "pre2", 1'b1, 32'h10010FFC, 32'h2222_2222, 0, 0);
        txn(0, "pre3", 1'b1, 32'h10010010, 32'hCAFE_F00D, 0, 0);
        txn(0, "t1_store", 1'b1, 32'h10010008, 32'hDEAD_BEEF, 0, 0);
        txn(0, "t2_load", 1'b0, 32'h10010008, '0, 0, 0);
        txn(0, "t3_misaligned", 1'b0, 32'h10010006, '0, 0, 0);
        txn(0, "t3_below", 1'b0, 32'h1000FFFC, '0, 0, 0);
        txn(0, "t3_unchanged", 1'b0, 32'h10010004, '0, 0, 0);
        txn(0, "t4_first", 1'b0, 32'h10010000, '0, 1, 0);
        txn(0, "t4_last", 1'b0, 32'h10010FFC, '0, 0, 0);
        txn(0, "t4_over", 1'b0, 32'h10011000, '0, 0, 0);
        txn(0, "store_fault_top", 1'b1, 32'hFFFF_FFFC, 32'h5555_5555, 0, 0);
        txn(0, "drop_store", 1'b1, 32'h10010014, 32'h7777_8888, 0, 1);
        txn(0, "drop_load", 1'b0, 32'h10010014, '0, 0, 0);
        reset_mid(32'h10010010, 32'h1234_5678);
        txn(0, "t5_load", 1'b0, 32'h10010010, '0, 0, 0);

        txn(1, "t6_store", 1'b1, 32'h10010020, 32'hA5A5_A5A5, 1, 0);
        txn(1, "t6_load", 1'b0, 32'h10010020, '0, 0, 0);

        rand_txn(0, 40);
        rand_txn(1, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
